if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipelined MIPS CPU. Holds the PC, drives the instruction-memory address, and registers the fetched word plus PC+4 into the IF/ID pipeline register consumed by the decode stage. Honours stall requests from the hazard unit and redirect/flush requests from the branch-resolution stage. Stops fetching when a halt word is fetched.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/ifid_reg.sv | 53 +++++
 rtl/if_fetch_stage.sv | 125 ++++++++++++
 tb/tb_if_fetch_stage.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, NOP encoding, reset/halt defaults and
// the fetch-stage state type.
package pipe_pkg;
   localparam int unsigned XLEN = 32;
   localparam int unsigned ILEN = 32;

   localparam logic [ILEN-1:0] NOP               = '0;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [ILEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

   typedef enum logic {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush inserts a NOP
// bubble, neither holds the current contents.
module ifid_reg
   import pipe_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            load_i,
   input  logic            flush_i,
   input  logic [31:0]     instr_i,
   input  logic [31:0]     pc4_i,
   output logic [31:0]     instr_o,
   output logic [31:0]     pc4_o,
   output logic            valid_o
);

   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc4_q,   pc4_d;
   logic            valid_q, valid_d;

   // flush takes precedence over load so a cancelled fetch never lands
   always_comb begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      if (flush_i) begin
         instr_d = NOP;
         pc4_d   = '0;
         valid_d = 1'b0;
      end else if (load_i) begin
         instr_d = instr_i;
         pc4_d   = pc4_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         instr_q <= NOP;
         pc4_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
      end
   end

   assign instr_o = instr_q;
   assign pc4_o   = pc4_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, FETCH/HALTED control and IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/stall/redirect performance counters.
module if_fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] ifid_instr_o,
   output logic [31:0] ifid_pc4_o,
   output logic        ifid_valid_o,
   output logic        halted_o,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] redirect_cnt_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4;
   logic            ifid_load, ifid_flush;

   assign pc_plus4 = pc_q + 32'd4;

   // priority: redirect > stall > normal fetch (RST handled in the registers)
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      if (redirect_i) begin
         pc_d       = {redirect_pc_i[31:2], 2'b00};
         ifid_flush = 1'b1;
         state_d    = FETCH;
      end else if (!stall_i) begin
         case (state_q)
            FETCH: begin
               if (imem_data_i != HALT_WORD) begin
                  ifid_load = 1'b1;
                  pc_d      = pc_plus4;
               end else begin
                  ifid_flush = 1'b1;
                  state_d    = HALTED;
               end
            end
            HALTED: ifid_flush = 1'b1;
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   ifid_reg u_ifid_reg (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .instr_i (imem_data_i),
      .pc4_i   (pc_plus4),
      .instr_o (ifid_instr_o),
      .pc4_o   (ifid_pc4_o),
      .valid_o (ifid_valid_o)
   );

   assign imem_addr_o = pc_q;
   assign pc_o        = pc_q;
   assign halted_o    = (state_q == HALTED);

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;

   // stall counting stops in HALTED; redirects are always counted
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (ifid_load)
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (stall_i && !redirect_i && (state_q == FETCH))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (redirect_i)
         redir_cnt_d = redir_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign fetch_cnt_o    = fetch_cnt_q;
   assign stall_cnt_o    = stall_cnt_q;
   assign redirect_cnt_o = redir_cnt_q;
`else
   assign fetch_cnt_o    = '0;
   assign stall_cnt_o    = '0;
   assign redirect_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage: stimulus pushes hand-computed
// post-edge expectations, a monitor pops and compares after each rising edge.
module tb_if_fetch_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        stall;
   logic        redir;
   logic [31:0] rpc;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] pc, instr, pc4;
   logic        valid, halted;
   logic [31:0] fcnt, scnt, rcnt;

   always #5 CLK = ~CLK;

   // instruction memory: 0x0 and 0x1C are special, others are 0x2000_0000|addr
   always_comb begin
      if (imem_addr == 32'h0000_0000)      imem_data = 32'h2001_0005;
      else if (imem_addr == 32'h0000_001C) imem_data = 32'hFFFF_FFFF;
      else                                 imem_data = 32'h2000_0000 | imem_addr;
   end

   if_fetch_stage dut (
      .CLK            (CLK),
      .RST            (RST),
      .stall_i        (stall),
      .redirect_i     (redir),
      .redirect_pc_i  (rpc),
      .imem_addr_o    (imem_addr),
      .imem_data_i    (imem_data),
      .pc_o           (pc),
      .ifid_instr_o   (instr),
      .ifid_pc4_o     (pc4),
      .ifid_valid_o   (valid),
      .halted_o       (halted),
      .fetch_cnt_o    (fcnt),
      .stall_cnt_o    (scnt),
      .redirect_cnt_o (rcnt)
   );

   typedef struct packed {
      logic        rst, stall, redir;
      logic [31:0] rpc, pc, instr, pc4;
      logic        valid, halted;
      logic [31:0] fc, sc, rc;
   } vec_t;

   vec_t stim_q[$];
   vec_t exp_q[$];
   int   step_q[$];
   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic v(input logic r, s, d, input logic [31:0] rp, p, i, p4,
                    input logic vl, h, input logic [31:0] f, st, rd);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = d; t.rpc = rp;
      t.pc = p; t.instr = i; t.pc4 = p4; t.valid = vl; t.halted = h;
      t.fc = f; t.sc = st; t.rc = rd;
      stim_q.push_back(t);
   endtask

   function automatic logic [31:0] cnt_exp(input logic [31:0] x);
`ifdef IF_PERF_CNT_EN
      return x;
`else
      return (x & 32'h0);
`endif
   endfunction

   task automatic chk(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL step%0d %s: got %h expected %h", step, name, got, exp);
      end
   endtask

   // monitor: the DUT presents a new IF-stage snapshot after every rising edge
   initial begin
      vec_t e;
      int   k;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = step_q.pop_front();
            chk("pc",        k, pc,                 e.pc);
            chk("imem_addr", k, imem_addr,          e.pc);
            chk("instr",     k, instr,              e.instr);
            chk("pc4",       k, pc4,                e.pc4);
            chk("valid",     k, {31'b0, valid},     {31'b0, e.valid});
            chk("halted",    k, {31'b0, halted},    {31'b0, e.halted});
            chk("fetch_cnt", k, fcnt,               cnt_exp(e.fc));
            chk("stall_cnt", k, scnt,               cnt_exp(e.sc));
            chk("redir_cnt", k, rcnt,               cnt_exp(e.rc));
         end
      end
   end

   initial begin
      vec_t t;
      RST = 1'b1; stall = 1'b0; redir = 1'b0; rpc = '0;

      //  rst stl red rpc            pc             instr          pc4            v  h  fc  sc rc
      v(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0,  0, 0);
      v(0, 0, 0, 32'h0,          32'h0000_0004, 32'h2001_0005, 32'h0000_0004, 1, 0, 1,  0, 0);
      v(0, 0, 0, 32'h0,          32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1, 0, 2,  0, 0);
      v(0, 1, 0, 32'h0,          32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1, 0, 2,  1, 0);
      v(0, 1, 0, 32'h0,          32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1, 0, 2,  2, 0);
      v(0, 1, 0, 32'h0,          32'h0000_0008, 32'h2000_0004, 32'h0000_0008, 1, 0, 2,  3, 0);
      v(0, 1, 1, 32'h40,         32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 0, 2,  3, 1);
      v(0, 0, 0, 32'h0,          32'h0000_0044, 32'h2000_0040, 32'h0000_0044, 1, 0, 3,  3, 1);
      v(0, 0, 1, 32'h43,         32'h0000_0040, 32'h0000_0000, 32'h0000_0000, 0, 0, 3,  3, 2);
      v(0, 0, 0, 32'h0,          32'h0000_0044, 32'h2000_0040, 32'h0000_0044, 1, 0, 4,  3, 2);
      v(0, 0, 1, 32'h14,         32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 0, 0, 4,  3, 3);
      v(0, 0, 0, 32'h0,          32'h0000_0018, 32'h2000_0014, 32'h0000_0018, 1, 0, 5,  3, 3);
      v(0, 0, 0, 32'h0,          32'h0000_001C, 32'h2000_0018, 32'h0000_001C, 1, 0, 6,  3, 3);
      v(0, 0, 0, 32'h0,          32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 0, 1, 6,  3, 3);
      for (int i = 0; i < 10; i++)
         v(0, (i == 4), 0, 32'h0, 32'h0000_001C, 32'h0000_0000, 32'h0000_0000, 0, 1, 6,  3, 3);
      v(0, 0, 1, 32'h20,         32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 0, 0, 6,  3, 4);
      v(0, 0, 0, 32'h0,          32'h0000_0024, 32'h2000_0020, 32'h0000_0024, 1, 0, 7,  3, 4);
      v(0, 0, 0, 32'h0,          32'h0000_0028, 32'h2000_0024, 32'h0000_0028, 1, 0, 8,  3, 4);
      v(0, 0, 0, 32'h0,          32'h0000_002C, 32'h2000_0028, 32'h0000_002C, 1, 0, 9,  3, 4);
      v(0, 0, 0, 32'h0,          32'h0000_0030, 32'h2000_002C, 32'h0000_0030, 1, 0, 10, 3, 4);
      v(1, 0, 0, 32'h0,          32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0, 0,  0, 0);
      v(0, 0, 0, 32'h0,          32'h0000_0004, 32'h2001_0005, 32'h0000_0004, 1, 0, 1,  0, 0);
      v(0, 0, 1, 32'hFFFF_FFFF,  32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 0, 0, 1,  0, 1);
      v(0, 0, 0, 32'h0,          32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 1, 0, 2,  0, 1);

      for (int s = 0; s < stim_q.size(); s++) begin
         @(negedge CLK);
         t = stim_q[s];
         RST = t.rst; stall = t.stall; redir = t.redir; rpc = t.rpc;
         exp_q.push_back(t);
         step_q.push_back(s);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(negedge CLK);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
